// File: rtl/mem_access_unit.sv
// Load/store sequencer between the memory stage and the data memory.
// Checks alignment, extends load data and does sub-word stores as read-modify-write.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  output logic [1:0]  dm_mode,
  input  logic [31:0] dm_dout
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] DM_WORD = 2'b00;
  localparam logic [1:0] DM_BYTE = 2'b01;
  localparam logic [1:0] DM_HALF = 2'b10;

  typedef enum logic [2:0] {IDLE, LD, LDW, ST, RMR, RMM, RMW, RESP} state_t;

  state_t        state;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          misalign_c;
  logic [1:0]    rd_mode_c;
  logic [DW-1:0] ext_c;
  logic [DW-1:0] merge_c;
  logic          unused_addr_c;

  // Upper address bits alias onto the 4 KiB data memory.
  assign unused_addr_c = ^req_addr[31:AW];

  always_comb begin
    misalign_c = 1'b0;
    rd_mode_c  = DM_WORD;
    case (req_size)
      SZ_BYTE: rd_mode_c  = DM_BYTE;
      SZ_HALF: begin
        misalign_c = req_addr[0];
        rd_mode_c  = DM_HALF;
      end
      SZ_WORD: misalign_c = |req_addr[1:0];
      default: misalign_c = 1'b1;
    endcase
  end

  // Memory returns sub-word reads right-aligned; only extension is needed here.
  always_comb begin
    ext_c = dm_dout;
    case (size_q)
      SZ_BYTE: ext_c = uns_q ? {24'h0, dm_dout[7:0]}  : {{24{dm_dout[7]}}, dm_dout[7:0]};
      SZ_HALF: ext_c = uns_q ? {16'h0, dm_dout[15:0]} : {{16{dm_dout[15]}}, dm_dout[15:0]};
      default: ext_c = dm_dout;
    endcase
  end

  always_comb begin
    merge_c = dm_dout;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_c[31:16] = wdata_q[15:0];
    end else begin
      merge_c[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      dm_we      <= 1'b0;
      dm_mode    <= DM_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            addr_q     <= req_addr[AW-1:0];
            wdata_q    <= req_wdata;
            req_ready  <= 1'b0;
            resp_rd    <= req_rd;
            resp_rdata <= '0;
            resp_err   <= misalign_c;
            // Errors spend one cycle in ST with the write enable held low.
            if (misalign_c) begin
              state <= ST;
            end else if (!req_we) begin
              state   <= LD;
              dm_addr <= req_addr[AW-1:0];
              dm_mode <= rd_mode_c;
            end else if (req_size == SZ_WORD) begin
              state   <= ST;
              dm_we   <= 1'b1;
              dm_addr <= req_addr[AW-1:0];
              dm_din  <= req_wdata;
              dm_mode <= DM_WORD;
            end else begin
              state   <= RMR;
              dm_addr <= {req_addr[AW-1:2], 2'b00};
              dm_mode <= DM_WORD;
            end
          end
        end
        LD: begin
          state   <= LDW;
          dm_addr <= '0;
          dm_mode <= DM_WORD;
        end
        LDW: begin
          state      <= RESP;
          resp_rdata <= ext_c;
          resp_valid <= 1'b1;
        end
        ST: begin
          state      <= RESP;
          dm_we      <= 1'b0;
          dm_addr    <= '0;
          dm_din     <= '0;
          resp_valid <= 1'b1;
        end
        RMR: begin
          state   <= RMM;
          dm_addr <= '0;
        end
        // Full-word write of the merged data keeps the neighbouring bytes intact.
        RMM: begin
          state   <= RMW;
          dm_we   <= 1'b1;
          dm_addr <= {addr_q[AW-1:2], 2'b00};
          dm_din  <= merge_c;
          dm_mode <= DM_WORD;
        end
        RMW: begin
          state      <= RESP;
          dm_we      <= 1'b0;
          dm_addr    <= '0;
          dm_din     <= '0;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data memory plus a response scoreboard.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [11:0] dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we;
  logic [1:0]  dm_mode;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  time         acc_t   = 0;
  time         hs_t    = 0;
  logic        rv_prev = 1'b0;
  logic        seen11  = 1'b0;
  logic [31:0] mem [0:1023];
  int          wr_count = 0;
  time         last_wr_t = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_mode(dm_mode),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Data memory: registered read, right-aligned sub-word data, sub-word writes zero the rest.
  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    w = mem[dm_addr[11:2]];
    case (dm_mode)
      2'b01:   dm_dout <= (w >> {dm_addr[1:0], 3'b000}) & 32'h0000_00FF;
      2'b10:   dm_dout <= (w >> {dm_addr[1], 4'b0000}) & 32'h0000_FFFF;
      default: dm_dout <= w;
    endcase
    if (dm_we) begin
      wr_count  <= wr_count + 1;
      last_wr_t <= $time;
      case (dm_mode)
        2'b00:   mem[dm_addr[11:2]] <= dm_din;
        2'b01:   mem[dm_addr[11:2]] <= (dm_din & 32'h0000_00FF) << {dm_addr[1:0], 3'b000};
        2'b10:   mem[dm_addr[11:2]] <= (dm_din & 32'h0000_FFFF) << {dm_addr[1], 4'b0000};
        default: mem[dm_addr[11:2]] <= 32'h0;
      endcase
    end
  end

  // Response monitor: latency at rise, payload at handshake.
  always @(negedge clk) begin
    if (dm_mode == 2'b11) seen11 = 1'b1;
    if (!rst_n) begin
      rv_prev = 1'b0;
    end else begin
      if (resp_valid && !rv_prev) begin
        if (sb.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'h0);
        else check("resp_latency", 32'(($time - acc_t - 5) / 10), 32'(sb[0].lat));
      end
      if (resp_valid && resp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
      end
      rv_prev = resp_valid;
    end
  end

  task automatic start_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                           input logic push, input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    if (push) begin
      e.rdata = er; e.rd = rd; e.err = ee; e.lat = lat;
      sb.push_back(e);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'h1);
    end else begin
      @(posedge clk);
      acc_t = $time;
      #1;
    end
    // Garbage after the accept edge must not affect the operation in flight.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic push, input logic [31:0] er, input logic ee, input int lat);
    @(negedge clk);
    start_req(we, sz, uns, a, wd, rd, push, er, ee, lat);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, input logic ee, input int lat);
    int wc0;
    wc0 = wr_count;
    do_req(1'b1, sz, 1'b0, a, wd, rd, 1'b1, 32'h0, ee, lat);
    wait_idle();
    if (ee) begin
      check("err_no_write", 32'(wr_count), 32'(wc0));
    end else begin
      check("st_wr_count", 32'(wr_count), 32'(wc0 + 1));
      check("st_wr_time", 32'(last_wr_t - acc_t), 32'(lat * 10));
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                    input logic [4:0] rd, input logic [31:0] er, input logic ee, input int lat);
    do_req(1'b0, sz, uns, a, 32'h0, rd, 1'b1, er, ee, lat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    rst_n = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_rd", 32'(resp_rd), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_dm_we", 32'(dm_we), 32'h0);
    check("rst_dm_mode", 32'(dm_mode), 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store / load round trip.
    st(2'b10, 32'h010, 32'hDEADBEEF, 5'd1, 1'b0, 1);
    ld(2'b10, 1'b0, 32'h010, 5'd2, 32'hDEADBEEF, 1'b0, 2);

    // Byte store as read-modify-write.
    st(2'b10, 32'h010, 32'h11223344, 5'd3, 1'b0, 1);
    st(2'b00, 32'h011, 32'hCCCCCCAA, 5'd4, 1'b0, 3);
    check("rmw_byte_mem", mem[4], 32'h1122AA44);
    ld(2'b10, 1'b0, 32'h010, 5'd5, 32'h1122AA44, 1'b0, 2);

    // Sub-word loads with sign and zero extension.
    st(2'b10, 32'h010, 32'h80FF0000, 5'd6, 1'b0, 1);
    ld(2'b00, 1'b0, 32'h013, 5'd9,  32'hFFFFFF80, 1'b0, 2);
    ld(2'b00, 1'b1, 32'h013, 5'd10, 32'h00000080, 1'b0, 2);
    ld(2'b01, 1'b0, 32'h012, 5'd11, 32'hFFFF80FF, 1'b0, 2);
    ld(2'b01, 1'b1, 32'h012, 5'd12, 32'h000080FF, 1'b0, 2);
    ld(2'b00, 1'b0, 32'h010, 5'd13, 32'h00000000, 1'b0, 2);
    ld(2'b00, 1'b0, 32'h012, 5'd14, 32'hFFFFFFFF, 1'b0, 2);

    // Half and byte RMW into other lanes, then aliased address load.
    st(2'b01, 32'h010, 32'hAAAA1234, 5'd15, 1'b0, 3);
    st(2'b00, 32'h013, 32'hFFFFFF5A, 5'd16, 1'b0, 3);
    ld(2'b10, 1'b0, 32'h010, 5'd17, 32'h5AFF1234, 1'b0, 2);
    ld(2'b10, 1'b0, 32'hABCDE010, 5'd18, 32'h5AFF1234, 1'b0, 2);

    // Misaligned and illegal-size accesses.
    st(2'b01, 32'h021, 32'h0000BEEF, 5'd19, 1'b1, 1);
    st(2'b10, 32'h012, 32'h12345678, 5'd20, 1'b1, 1);
    check("err_mem_untouched", mem[4], 32'h5AFF1234);
    wc0 = wr_count;
    ld(2'b10, 1'b0, 32'h022, 5'd21, 32'h0, 1'b1, 1);
    ld(2'b11, 1'b0, 32'h020, 5'd22, 32'h0, 1'b1, 1);
    check("err_ld_no_write", 32'(wr_count), 32'(wc0));

    // Back-pressure: response held, next accept right after the handshake.
    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 5'd7, 1'b1, 32'h5AFF1234, 1'b0, 2);
    for (int n = 0; n < 10 && !resp_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", 32'(resp_valid), 32'h1);
      check("stall_resp_rdata", resp_rdata, 32'h5AFF1234);
      check("stall_resp_rd", 32'(resp_rd), 32'd7);
      check("stall_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    hs_t = $time - 1 + 10;
    start_req(1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 5'd8, 1'b1, 32'h00001234, 1'b0, 2);
    wait_accept();
    check("next_accept_delay", 32'(acc_t - hs_t), 32'd10);
    wait_idle();

    // Reset during RMM of a half store: no write, no response.
    st(2'b10, 32'h030, 32'h11223344, 5'd23, 1'b0, 1);
    wc0 = wr_count;
    do_req(1'b1, 2'b01, 1'b0, 32'h032, 32'h0000BEEF, 5'd24, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_dm_we", 32'(dm_we), 32'h0);
    check("rstmid_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstrel_req_ready", 32'(req_ready), 32'h1);
    check("rstrel_resp_valid", 32'(resp_valid), 32'h0);
    repeat (4) @(negedge clk);
    check("rstrel_resp_valid_later", 32'(resp_valid), 32'h0);
    check("rstmid_no_write", 32'(wr_count), 32'(wc0));
    check("rstmid_mem", mem[12], 32'h11223344);
    ld(2'b10, 1'b0, 32'h030, 5'd25, 32'h11223344, 1'b0, 2);

    check("dm_mode_11_seen", 32'(seen11), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
